// File: rtl/elevator_floor_ctrl.sv
// -----------------------------------------------------------------------------
// elevator_floor_ctrl
// Single-car elevator controller with SCAN scheduling. Floor calls are latched
// into a pending vector. The car keeps moving in its last direction while calls
// remain ahead, then reverses. Travel between adjacent floors and the door dwell
// are both timed by down-counters.
//
// Ports
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   req         : floor-call request bits, one per floor, sampled every clk
//   floor       : current car floor, binary, feeds the 7-segment decoder
//   moving_up   : high while the car travels upward
//   moving_down : high while the car travels downward
//   door_open   : high while the door is open
//   pending     : latched outstanding calls
// -----------------------------------------------------------------------------
module elevator_floor_ctrl #(
    parameter int NUM_FLOORS    = 10,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] req,
    output logic [3:0]            floor,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam logic [TW-1:0]         TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0]         TRAVEL_ONE  = TW'(1);
    localparam logic [DW-1:0]         DOOR_LOAD   = DW'(DOOR_CYCLES - 1);
    localparam logic [DW-1:0]         DOOR_ONE    = DW'(1);
    localparam logic [NUM_FLOORS-1:0] PEND_ONE    = NUM_FLOORS'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_floor;
    logic [NUM_FLOORS-1:0]   r_pending;
    logic                    r_last_up;
    logic [TW-1:0]           r_travel_cnt;
    logic [DW-1:0]           r_door_cnt;

    state_t                  w_state_nxt;
    logic [3:0]              w_floor_nxt;
    logic                    w_last_up_nxt;
    logic [TW-1:0]           w_travel_nxt;
    logic [DW-1:0]           w_door_nxt;
    logic                    w_clr_en;
    logic [3:0]              w_clr_floor;
    logic [NUM_FLOORS-1:0]   w_clr;
    logic [NUM_FLOORS-1:0]   w_above_mask;
    logic [NUM_FLOORS-1:0]   w_below_mask;
    logic                    w_above;
    logic                    w_below;
    logic                    w_here;
    logic [3:0]              w_floor_up;
    logic [3:0]              w_floor_dn;

    // Floor-relative masks of the pending vector; at the end floors one mask is
    // empty, so the car can never be scheduled past floor 0 or the top floor.
    always_comb begin
        w_above_mask = '0;
        w_below_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_above_mask[i] = (i > int'(r_floor));
            w_below_mask[i] = (i < int'(r_floor));
        end
        w_above    = |(r_pending & w_above_mask);
        w_below    = |(r_pending & w_below_mask);
        w_here     = r_pending[r_floor];
        w_floor_up = r_floor + 4'd1;
        w_floor_dn = r_floor - 4'd1;
    end

    // Next-state, counter and call-clear decode for the car FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_floor_nxt   = r_floor;
        w_last_up_nxt = r_last_up;
        w_travel_nxt  = r_travel_cnt;
        w_door_nxt    = r_door_cnt;
        w_clr_en      = 1'b0;
        w_clr_floor   = r_floor;
        case (r_state)
            IDLE: begin
                if (w_here) begin
                    w_state_nxt = DOOR;
                    w_door_nxt  = DOOR_LOAD;
                    w_clr_en    = 1'b1;
                end else if (r_last_up && w_above) begin
                    w_state_nxt  = MOVE_UP;
                    w_travel_nxt = TRAVEL_LOAD;
                end else if (!r_last_up && w_below) begin
                    w_state_nxt  = MOVE_DOWN;
                    w_travel_nxt = TRAVEL_LOAD;
                end else if (w_above) begin
                    w_state_nxt   = MOVE_UP;
                    w_travel_nxt  = TRAVEL_LOAD;
                    w_last_up_nxt = 1'b1;
                end else if (w_below) begin
                    w_state_nxt   = MOVE_DOWN;
                    w_travel_nxt  = TRAVEL_LOAD;
                    w_last_up_nxt = 1'b0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            MOVE_UP: begin
                if (r_travel_cnt == {TW{1'b0}}) begin
                    w_floor_nxt = w_floor_up;
                    // The arrival edge is also the door entry edge, so the
                    // call for the new floor is cleared right here.
                    if (r_pending[w_floor_up]) begin
                        w_state_nxt = DOOR;
                        w_door_nxt  = DOOR_LOAD;
                        w_clr_en    = 1'b1;
                        w_clr_floor = w_floor_up;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_travel_nxt = r_travel_cnt - TRAVEL_ONE;
                end
            end
            MOVE_DOWN: begin
                if (r_travel_cnt == {TW{1'b0}}) begin
                    w_floor_nxt = w_floor_dn;
                    if (r_pending[w_floor_dn]) begin
                        w_state_nxt = DOOR;
                        w_door_nxt  = DOOR_LOAD;
                        w_clr_en    = 1'b1;
                        w_clr_floor = w_floor_dn;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_travel_nxt = r_travel_cnt - TRAVEL_ONE;
                end
            end
            DOOR: begin
                // A call at this floor while open keeps the door open instead
                // of being latched.
                w_clr_en = 1'b1;
                if (req[r_floor]) begin
                    w_door_nxt = DOOR_LOAD;
                end else if (r_door_cnt == {DW{1'b0}}) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_door_nxt = r_door_cnt - DOOR_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_clr = w_clr_en ? (PEND_ONE << w_clr_floor) : {NUM_FLOORS{1'b0}};
    end

    // Car state, position, direction memory, timers and latched calls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_floor      <= 4'd0;
            r_pending    <= {NUM_FLOORS{1'b0}};
            r_last_up    <= 1'b1;
            r_travel_cnt <= {TW{1'b0}};
            r_door_cnt   <= {DW{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_floor      <= w_floor_nxt;
            r_pending    <= (r_pending | req) & ~w_clr;
            r_last_up    <= w_last_up_nxt;
            r_travel_cnt <= w_travel_nxt;
            r_door_cnt   <= w_door_nxt;
        end
    end

    assign floor       = r_floor;
    assign pending     = r_pending;
    assign moving_up   = (r_state == MOVE_UP);
    assign moving_down = (r_state == MOVE_DOWN);
    assign door_open   = (r_state == DOOR);

endmodule

// File: tb/tb_elevator_floor_ctrl.sv
// -----------------------------------------------------------------------------
// tb_elevator_floor_ctrl
// Self-checking bench for elevator_floor_ctrl (10 floors, 8 travel cycles,
// 6 door cycles). Cycle-exact traces are table-driven; multi-cycle scenarios
// use a door-stop scoreboard: the expected stop floor is queued when a call is
// driven and popped when the door opens.
// -----------------------------------------------------------------------------
module tb_elevator_floor_ctrl;

    logic       clk;
    logic       rst_n;
    logic [9:0] req;
    logic [3:0] floor;
    logic       moving_up;
    logic       moving_down;
    logic       door_open;
    logic [9:0] pending;

    elevator_floor_ctrl #(
        .NUM_FLOORS    (10),
        .TRAVEL_CYCLES (8),
        .DOOR_CYCLES   (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .floor       (floor),
        .moving_up   (moving_up),
        .moving_down (moving_down),
        .door_open   (door_open),
        .pending     (pending)
    );

    typedef struct {
        logic [9:0] req;
        logic [3:0] floor;
        logic       up;
        logic       dn;
        logic       door;
        logic [9:0] pend;
        int         test;
    } vec_t;

    vec_t       vecs[$];
    vec_t       exp_q[$];
    int         door_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       mon_en   = 1'b0;
    logic       prev_door = 1'b0;
    int         max_floor = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [9:0] r, input logic [3:0] f, input logic u,
                                input logic d, input logic o, input logic [9:0] p, input int t);
        vec_t v;
        v.req = r; v.floor = f; v.up = u; v.dn = d; v.door = o; v.pend = p; v.test = t;
        return v;
    endfunction

    task automatic pulse(input logic [9:0] mask);
        @(negedge clk);
        req = mask;
        @(negedge clk);
        req = 10'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_up_at(input logic [3:0] f, input int bound, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (moving_up && floor == f) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_quiet(input int bound, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (door_q.size() == 0 && !moving_up && !moving_down && !door_open && pending == 10'd0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    // Door-stop scoreboard: each door opening must match the oldest queued floor.
    always @(negedge clk) begin
        if (mon_en && rst_n && door_open && !prev_door) begin
            if (door_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL door_unexpected: actual floor %0d required no stop", floor);
            end else begin
                check("door_floor", {28'd0, floor}, door_q.pop_front());
            end
        end
        if (int'(floor) > max_floor) max_floor = int'(floor);
        prev_door = door_open;
    end

    initial begin
        vec_t e;
        logic [3:0] f;
        logic       u;
        logic       o;

        rst_n = 1'b0;
        req   = 10'd0;

        // Test 1: idle, no calls.
        for (int t = 0; t < 20; t++) vecs.push_back(mk(10'd0, 4'd0, 1'b0, 1'b0, 1'b0, 10'd0, 1));
        // Test 2: single pulse for floor 3 at t=0.
        vecs.push_back(mk(10'b0000001000, 4'd0, 1'b0, 1'b0, 1'b0, 10'b0000001000, 2));
        for (int t = 1; t <= 34; t++) begin
            u = ((t >= 1 && t <= 8) || (t >= 10 && t <= 17) || (t >= 19 && t <= 26));
            f = (t < 9) ? 4'd0 : (t < 18) ? 4'd1 : (t < 27) ? 4'd2 : 4'd3;
            o = (t >= 27 && t <= 32);
            vecs.push_back(mk(10'd0, f, u, 1'b0, o, (t < 27) ? 10'b0000001000 : 10'd0, 2));
        end
        // Test 3: hold call for current floor 3 for 10 cycles.
        vecs.push_back(mk(10'b0000001000, 4'd3, 1'b0, 1'b0, 1'b0, 10'b0000001000, 3));
        for (int t = 1; t <= 17; t++) begin
            vecs.push_back(mk((t <= 9) ? 10'b0000001000 : 10'd0, 4'd3, 1'b0, 1'b0,
                              (t <= 14), 10'd0, 3));
        end

        repeat (3) @(negedge clk);
        check("reset_state", {15'd0, floor, moving_up, moving_down, door_open, pending}, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            req = vecs[i].req;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("vec%0d_test%0d", i, e.test),
                  {15'd0, floor, moving_up, moving_down, door_open, pending},
                  {15'd0, e.floor, e.up, e.dn, e.door, e.pend});
        end
        @(negedge clk);
        req = 10'd0;

        // Test 4: calls above and below while leaving floor 2 upward.
        do_reset();
        mon_en = 1'b1;
        door_q.push_back(3);
        pulse(10'b0000001000);
        wait_up_at(4'd2, 100, "t4_leave_floor2");
        door_q.push_back(5);
        door_q.push_back(1);
        pulse(10'b0000100010);
        wait_quiet(500, "t4_quiet");
        check("t4_final_floor", {28'd0, floor}, 32'd1);
        check("t4_pending", {22'd0, pending}, 32'd0);

        // Test 5: reset mid-travel between floors 4 and 5 with a call for 7.
        do_reset();
        pulse(10'b0010000000);
        wait_up_at(4'd4, 200, "t5_leave_floor4");
        repeat (3) @(negedge clk);
        check("t5_pending_before", {22'd0, pending}, 32'h80);
        rst_n = 1'b0;
        #1;
        check("t5_async_reset", {15'd0, floor, moving_up, moving_down, door_open, pending}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            check($sformatf("t5_no_motion%0d", t),
                  {15'd0, floor, moving_up, moving_down, door_open, pending}, 32'd0);
        end

        // Test 6: travel to the top floor, then serve floor 9 and floor 0.
        door_q.push_back(9);
        pulse(10'b1000000000);
        wait_quiet(300, "t6_reach_top");
        check("t6_at_top", {28'd0, floor}, 32'd9);
        max_floor = 0;
        door_q.push_back(9);
        pulse(10'b1000000000);
        door_q.push_back(0);
        pulse(10'b0000000001);
        wait_quiet(300, "t6_quiet");
        check("t6_final_floor", {28'd0, floor}, 32'd0);
        check("t6_max_floor", max_floor, 32'd9);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
